// File: rtl/alu_result_monitor_if.sv
// Bundles the ALU capture side and the framed output stream of alu_result_monitor.
interface alu_result_monitor_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  enable;
  logic [DATA_WIDTH-1:0] ex_alu;
  logic                  ex_alu_vld;
  logic [15:0]           tx_data;
  logic                  tx_sof;
  logic                  tx_eof;
  logic                  tx_vld;
  logic                  tx_rdy;
  logic                  overflow;
  logic [15:0]           drop_cnt;

  // Environment side: produces ALU results, consumes the stream
  modport master (
    output enable, ex_alu, ex_alu_vld, tx_rdy,
    input  tx_data, tx_sof, tx_eof, tx_vld, overflow, drop_cnt
  );

  // Monitor side
  modport slave (
    input  enable, ex_alu, ex_alu_vld, tx_rdy,
    output tx_data, tx_sof, tx_eof, tx_vld, overflow, drop_cnt
  );
endinterface

// File: rtl/alu_result_monitor.sv
// Captures ALU results tagged with an 8-bit sequence number into a FIFO and
// streams each one out as a two-word frame: header {A5, seq} then the result.
module alu_result_monitor #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic                clk,
  input logic                rst,
  alu_result_monitor_if.slave bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHdr  = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    seq_q;
  logic          overflow_q;
  logic [15:0]   drop_cnt_q;

  logic          evt, full, empty, push, pop, drop;
  logic [EW-1:0] head;

  assign evt   = bus.enable & bus.ex_alu_vld;
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = evt & ~full;
  // A pop in the same cycle cannot make room for a full-FIFO event
  assign drop  = evt & full;
  assign pop   = (state_q == StData) & bus.tx_rdy;
  assign head  = mem_q[rd_ptr_q];

  // FIFO occupancy next state
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencing: header, then data, then next header or idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!empty) state_d = StHdr;
      StHdr:   if (bus.tx_rdy) state_d = StData;
      StData:  if (bus.tx_rdy) state_d = (count_q > CW'(1)) ? StHdr : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state, pointers, sequence and drop statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (evt)  seq_q    <= seq_q + 8'd1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // Result storage; contents are meaningless while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {seq_q, bus.ex_alu};
  end

  // Stream outputs decode from state and FIFO head only, never from tx_rdy
  always_comb begin
    bus.tx_vld  = 1'b0;
    bus.tx_sof  = 1'b0;
    bus.tx_eof  = 1'b0;
    bus.tx_data = '0;
    case (state_q)
      StHdr: begin
        bus.tx_vld  = 1'b1;
        bus.tx_sof  = 1'b1;
        bus.tx_data = {8'hA5, head[EW-1 -: 8]};
      end
      StData: begin
        bus.tx_vld  = 1'b1;
        bus.tx_eof  = 1'b1;
        bus.tx_data = 16'(head[DATA_WIDTH-1:0]);
      end
      default: ;
    endcase
  end

  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_alu_result_monitor.sv
// Directed bench for alu_result_monitor with hand-computed frames.
module tb_alu_result_monitor;

  logic clk;
  logic rst;

  alu_result_monitor_if #(.DATA_WIDTH(8)) bus ();

  alu_result_monitor #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] prev_hdr;
  logic [15:0] last_hdr;
  int          hdr_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " vld"},  32'(bus.tx_vld), 32'h0);
    check({tag, " sof"},  32'(bus.tx_sof), 32'h0);
    check({tag, " eof"},  32'(bus.tx_eof), 32'h0);
    check({tag, " data"}, 32'(bus.tx_data), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_idle("reset");
    check("reset overflow", 32'(bus.overflow), 32'h0);
    check("reset drop_cnt", 32'(bus.drop_cnt), 32'h0);
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    bus.ex_alu     = v;
    bus.ex_alu_vld = 1'b1;
    tick();
    bus.ex_alu_vld = 1'b0;
  endtask

  // Waits (bounded) for a valid word, checks it, then lets it be accepted
  task automatic recv_word(input string tag, input logic [15:0] d, input logic sof,
                           input logic eof);
    int n;
    n = 0;
    while (!bus.tx_vld && n < 50) begin
      tick();
      n++;
    end
    check({tag, " vld"},  32'(bus.tx_vld), 32'h1);
    check({tag, " data"}, 32'(bus.tx_data), 32'(d));
    check({tag, " sof"},  32'(bus.tx_sof), 32'(sof));
    check({tag, " eof"},  32'(bus.tx_eof), 32'(eof));
    tick();
  endtask

  task automatic check_frame(input string tag, input logic [7:0] seq, input logic [7:0] res);
    recv_word({tag, " hdr"}, {8'hA5, seq}, 1'b1, 1'b0);
    recv_word({tag, " dat"}, {8'h00, res}, 1'b0, 1'b1);
  endtask

  task automatic sample_hdr();
    if (bus.tx_vld && bus.tx_sof) begin
      prev_hdr = last_hdr;
      last_hdr = bus.tx_data;
      hdr_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] exp6 [6];
    int          unstable;

    rst            = 1'b1;
    bus.enable     = 1'b1;
    bus.ex_alu     = '0;
    bus.ex_alu_vld = 1'b0;
    bus.tx_rdy     = 1'b0;
    tick();

    // Single result with one-cycle capture-to-header latency
    do_reset();
    send(8'h3C);
    check("single latency vld", 32'(bus.tx_vld), 32'h0);
    tick();
    check("single hdr data", 32'(bus.tx_data), 32'hA500);
    check("single hdr sof",  32'(bus.tx_sof), 32'h1);
    check("single hdr eof",  32'(bus.tx_eof), 32'h0);
    bus.tx_rdy = 1'b1;
    tick();
    check("single dat data", 32'(bus.tx_data), 32'h003C);
    check("single dat eof",  32'(bus.tx_eof), 32'h1);
    check("single dat sof",  32'(bus.tx_sof), 32'h0);
    tick();
    check_idle("single after");

    // Backpressure: words held while stalled, then six contiguous words
    do_reset();
    bus.tx_rdy = 1'b0;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.tx_vld || !bus.tx_sof || bus.tx_data != 16'hA500) unstable++;
      tick();
    end
    check("bp stall unstable cycles", 32'(unstable), 32'h0);
    exp6 = '{16'hA500, 16'h0001, 16'hA501, 16'h0002, 16'hA502, 16'h0003};
    bus.tx_rdy = 1'b1;
    for (int j = 0; j < 6; j++) begin
      check($sformatf("bp word%0d vld", j),  32'(bus.tx_vld), 32'h1);
      check($sformatf("bp word%0d data", j), 32'(bus.tx_data), 32'(exp6[j]));
      check($sformatf("bp word%0d sof", j),  32'(bus.tx_sof), 32'((j % 2) == 0));
      tick();
    end
    check("bp after vld", 32'(bus.tx_vld), 32'h0);

    // Overflow: 10 events into an 8-entry FIFO, no draining
    do_reset();
    bus.tx_rdy = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(16 + i));
    check("ovf overflow", 32'(bus.overflow), 32'h1);
    check("ovf drop_cnt", 32'(bus.drop_cnt), 32'h2);
    bus.tx_rdy = 1'b1;
    for (int i = 0; i < 8; i++) check_frame($sformatf("ovf f%0d", i), 8'(i), 8'(16 + i));
    send(8'h77);
    check_frame("ovf next", 8'h0A, 8'h77);
    check("ovf sticky", 32'(bus.overflow), 32'h1);
    check("ovf drop_cnt hold", 32'(bus.drop_cnt), 32'h2);

    // Sequence wrap: 257 events two cycles apart, streamed without drops
    do_reset();
    bus.tx_rdy = 1'b1;
    prev_hdr   = '0;
    last_hdr   = '0;
    hdr_cnt    = 0;
    for (int i = 0; i < 257; i++) begin
      bus.ex_alu     = 8'(i);
      bus.ex_alu_vld = 1'b1;
      tick();
      bus.ex_alu_vld = 1'b0;
      sample_hdr();
      tick();
      sample_hdr();
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      sample_hdr();
    end
    check("wrap header count", 32'(hdr_cnt), 32'd257);
    check("wrap penultimate hdr", 32'(prev_hdr), 32'hA5FF);
    check("wrap last hdr", 32'(last_hdr), 32'hA500);
    check("wrap drop_cnt", 32'(bus.drop_cnt), 32'h0);
    check("wrap overflow", 32'(bus.overflow), 32'h0);

    // Enable gating, including while the FIFO is full
    do_reset();
    bus.tx_rdy = 1'b0;
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) send(8'hE0);
    tick();
    check("gate no frame vld", 32'(bus.tx_vld), 32'h0);
    bus.enable = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(64 + i));
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) send(8'hE1);
    check("gate full drop_cnt", 32'(bus.drop_cnt), 32'h0);
    check("gate full overflow", 32'(bus.overflow), 32'h0);
    bus.enable = 1'b1;
    send(8'hEE);
    check("gate enabled drop_cnt", 32'(bus.drop_cnt), 32'h1);
    check("gate enabled overflow", 32'(bus.overflow), 32'h1);
    bus.tx_rdy = 1'b1;
    for (int i = 0; i < 8; i++) check_frame($sformatf("gate f%0d", i), 8'(i), 8'(64 + i));
    send(8'h55);
    check_frame("gate next", 8'h09, 8'h55);

    // Reset in the middle of a stalled data word
    do_reset();
    bus.tx_rdy = 1'b0;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    bus.tx_rdy = 1'b1;
    tick();
    bus.tx_rdy = 1'b0;
    check("mid dat eof",  32'(bus.tx_eof), 32'h1);
    check("mid dat data", 32'(bus.tx_data), 32'h0011);
    #2;
    rst = 1'b1;
    #1;
    check_idle("mid async");
    tick();
    rst = 1'b0;
    bus.tx_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid no resume%0d", i), 32'(bus.tx_vld), 32'h0);
    end
    check("mid drop_cnt", 32'(bus.drop_cnt), 32'h0);
    send(8'hC3);
    check_frame("mid next", 8'h00, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
